// File: rtl/aes_pkg.sv
// Shared definitions for the AES-256 round-key generator.
// Holds FSM state encoding, word/round-key widths, the initial Rcon value and
// GF(2^8) helpers used to build the byte S-box.
package aes_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned RK_W   = 128;
  localparam int unsigned WIN_W  = 256;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned RCON_W = 8;

  localparam logic [RCON_W-1:0] RCON_INIT = 8'h01;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EMIT_HI = 3'd1,
    ST_EMIT_LO = 3'd2,
    ST_EXPAND  = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h01;
    s = a;
    for (int i = 1; i < 8; i++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r;
  endfunction

  // Forward AES S-box: inverse followed by the affine transform.
  function automatic logic [7:0] sbox_byte(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_sbox_word.sv
// SubWord: applies the AES S-box to each byte of a 32-bit word.
// Ports:
//   word  - input word
//   subst - substituted word (purely combinational)
module aes_sbox_word
  import aes_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  output logic [WORD_W-1:0] subst
);

  // One byte S-box per lane.
  for (genvar b = 0; b < 4; b++) begin : g_byte
    assign subst[8*b +: 8] = sbox_byte(word[8*b +: 8]);
  end

endmodule

// File: rtl/aes_round_key_gen.sv
// AES-256 round-key generator. Streams 128-bit round keys from an external
// 256-bit key schedule window (two keys per window) over a valid/ready
// handshake, and asks the schedule register to advance one window between
// pairs using the Nk=8 expansion rule.
// Ports:
//   inClk/inRst               - clock, synchronous active-high reset
//   inStart                   - begin a sequence (sampled only in IDLE)
//   inKeyData/inKeyRcon       - current schedule window and Rcon
//   outKeyWr/outKeyData/outKeyRcon - one-cycle write of the next window/Rcon
//   outRkValid/inRkReady      - round-key handshake
//   outRk/outRkIdx            - round key and its index
//   outBusy/outDone           - activity flag and end-of-sequence pulse
// Build option: define AES_RKGEN_PIPE_EN to split the expansion over two
// cycles (n0..n3 registered first, write strobe in the second cycle).
module aes_round_key_gen
  import aes_pkg::*;
#(
  parameter int unsigned LAST_IDX = 14
) (
  input  logic                inClk,
  input  logic                inRst,
  input  logic                inStart,
  input  logic [WIN_W-1:0]    inKeyData,
  input  logic [RCON_W-1:0]   inKeyRcon,
  output logic                outKeyWr,
  output logic [WIN_W-1:0]    outKeyData,
  output logic [RCON_W-1:0]   outKeyRcon,
  output logic                outRkValid,
  input  logic                inRkReady,
  output logic [RK_W-1:0]     outRk,
  output logic [IDX_W-1:0]    outRkIdx,
  output logic                outBusy,
  output logic                outDone
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(LAST_IDX);

  state_t           state;
  logic [IDX_W-1:0] idx_q;
  logic             rk_valid_q;
  logic             key_wr_q;
  logic             busy_q;
  logic             done_q;

`ifdef AES_RKGEN_PIPE_EN
  logic             ph_q;   // 0: first EXPAND cycle, 1: write cycle
  logic [RK_W-1:0]  lo_q;   // registered n0..n3
`endif

  logic [WORD_W-1:0] w0, w1, w2, w3, w4, w5, w6, w7;
  logic [WORD_W-1:0] n0, n1, n2, n3, n4, n5, n6, n7;
  logic [WORD_W-1:0] rot7, sub_rot, n3_src, sub_n3;
  logic [RK_W-1:0]   hi_src;
  logic [WIN_W-1:0]  next_win;

  // Split the window into words; w0 sits in the top bits.
  assign w0 = inKeyData[255:224];
  assign w1 = inKeyData[223:192];
  assign w2 = inKeyData[191:160];
  assign w3 = inKeyData[159:128];
  assign w4 = inKeyData[127:96];
  assign w5 = inKeyData[95:64];
  assign w6 = inKeyData[63:32];
  assign w7 = inKeyData[31:0];

  assign rot7 = {w7[23:0], w7[31:24]};

  aes_sbox_word u_sbox_rot (
    .word  (rot7),
    .subst (sub_rot)
  );

  // First half of the new window.
  always_comb begin
    n0 = w0 ^ sub_rot ^ {inKeyRcon, 24'h000000};
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
  end

  // In the pipelined build the second half works from the registered n3.
`ifdef AES_RKGEN_PIPE_EN
  assign n3_src = lo_q[WORD_W-1:0];
  assign hi_src = lo_q;
`else
  assign n3_src = n3;
  assign hi_src = {n0, n1, n2, n3};
`endif

  aes_sbox_word u_sbox_n3 (
    .word  (n3_src),
    .subst (sub_n3)
  );

  // Second half of the new window.
  always_comb begin
    n4 = w4 ^ sub_n3;
    n5 = w5 ^ n4;
    n6 = w6 ^ n5;
    n7 = w7 ^ n6;
  end

  assign next_win = {hi_src, n4, n5, n6, n7};

  // Data outputs are gated so they read zero outside their valid windows.
  assign outKeyData = key_wr_q ? next_win : '0;
  assign outKeyRcon = key_wr_q ? {inKeyRcon[6:0], 1'b0} : '0;
  assign outRk      = !rk_valid_q          ? '0 :
                      (state == ST_EMIT_LO) ? inKeyData[127:0] : inKeyData[255:128];

  assign outKeyWr   = key_wr_q;
  assign outRkValid = rk_valid_q;
  assign outRkIdx   = idx_q;
  assign outBusy    = busy_q;
  assign outDone    = done_q;

  // Sequencer with registered control outputs.
  always_ff @(posedge inClk) begin
    if (inRst) begin
      state      <= ST_IDLE;
      idx_q      <= '0;
      rk_valid_q <= 1'b0;
      key_wr_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef AES_RKGEN_PIPE_EN
      ph_q       <= 1'b0;
      lo_q       <= '0;
`endif
    end else begin
      key_wr_q <= 1'b0;
      done_q   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (inStart) begin
            state      <= ST_EMIT_HI;
            idx_q      <= '0;
            rk_valid_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        ST_EMIT_HI: begin
          if (inRkReady) begin
            idx_q <= idx_q + IDX_W'(1);
            if (idx_q == LAST) begin
              state      <= ST_DONE;
              rk_valid_q <= 1'b0;
              done_q     <= 1'b1;
            end else begin
              state <= ST_EMIT_LO;
            end
          end
        end
        ST_EMIT_LO: begin
          if (inRkReady) begin
            idx_q      <= idx_q + IDX_W'(1);
            rk_valid_q <= 1'b0;
            if (idx_q == LAST) begin
              state  <= ST_DONE;
              done_q <= 1'b1;
            end else begin
              state <= ST_EXPAND;
`ifdef AES_RKGEN_PIPE_EN
              ph_q  <= 1'b0;
`else
              key_wr_q <= 1'b1;
`endif
            end
          end
        end
        ST_EXPAND: begin
`ifdef AES_RKGEN_PIPE_EN
          if (!ph_q) begin
            ph_q     <= 1'b1;
            lo_q     <= {n0, n1, n2, n3};
            key_wr_q <= 1'b1;
          end else begin
            ph_q       <= 1'b0;
            state      <= ST_EMIT_HI;
            rk_valid_q <= 1'b1;
          end
`else
          state      <= ST_EMIT_HI;
          rk_valid_q <= 1'b1;
`endif
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
          idx_q  <= '0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_key_gen.sv
// Directed bench for aes_round_key_gen with a key-schedule register model in
// the loop and a scoreboard of expected round keys built from an independent
// table-based FIPS-197 key expansion.
module tb_aes_round_key_gen;

  localparam logic [255:0] KEY0 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
`ifdef AES_RKGEN_PIPE_EN
  localparam int EXP_LAT = 4;
`else
  localparam int EXP_LAT = 3;
`endif

  logic         inClk, inRst, inStart, inRkReady;
  logic [255:0] inKeyData;
  logic [7:0]   inKeyRcon;
  logic         outKeyWr, outRkValid, outBusy, outDone;
  logic [255:0] outKeyData;
  logic [7:0]   outKeyRcon;
  logic [127:0] outRk;
  logic [3:0]   outRkIdx;

  aes_round_key_gen #(.LAST_IDX(14)) dut (
    .inClk      (inClk),
    .inRst      (inRst),
    .inStart    (inStart),
    .inKeyData  (inKeyData),
    .inKeyRcon  (inKeyRcon),
    .outKeyWr   (outKeyWr),
    .outKeyData (outKeyData),
    .outKeyRcon (outKeyRcon),
    .outRkValid (outRkValid),
    .inRkReady  (inRkReady),
    .outRk      (outRk),
    .outRkIdx   (outRkIdx),
    .outBusy    (outBusy),
    .outDone    (outDone)
  );

  initial inClk = 1'b0;
  always #5 inClk = ~inClk;

  // Key schedule register model.
  logic         ld_en;
  logic [255:0] reg_key;
  logic [7:0]   reg_rcon;
  always @(posedge inClk) begin
    if (ld_en) begin
      reg_key  <= KEY0;
      reg_rcon <= 8'h01;
    end else if (outKeyWr) begin
      reg_key  <= outKeyData;
      reg_rcon <= outKeyRcon;
    end
  end
  assign inKeyData = reg_key;
  assign inKeyRcon = reg_rcon;

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference S-box table.
  logic [0:2047] sbox_bits = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = sbox_bits[8*int'(x[8*b +: 8]) +: 8];
    return r;
  endfunction

  logic [31:0]  wm [60];
  logic [127:0] exp_rk [15];

  task automatic build_model();
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 8; i++) wm[i] = KEY0[255-32*i -: 32];
    rc = 8'h01;
    for (int i = 8; i < 60; i++) begin
      t = wm[i-1];
      if (i % 8 == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = {rc[6:0], 1'b0};
      end else if (i % 8 == 4) begin
        t = sub_word(t);
      end
      wm[i] = wm[i-8] ^ t;
    end
    for (int k = 0; k < 15; k++) exp_rk[k] = {wm[4*k], wm[4*k+1], wm[4*k+2], wm[4*k+3]};
  endtask

  // Scoreboard of expected transfers.
  typedef struct packed {
    logic [3:0]   idx;
    logic [127:0] rk;
  } sb_t;
  sb_t sb [$];

  task automatic push_all();
    sb_t e;
    for (int k = 0; k < 15; k++) begin
      e.idx = 4'(k);
      e.rk  = exp_rk[k];
      sb.push_back(e);
    end
  endtask

  int           xfers = 0;
  logic [127:0] rk14_seen = '0;

  // Transfer monitor, sampled mid-cycle.
  always @(negedge inClk) begin
    sb_t e;
    if (outRkValid && inRkReady) begin
      xfers++;
      if (outRkIdx == 4'd14) rk14_seen = outRk;
      chk("sb_nonempty", 256'(sb.size() != 0), 256'(1'b1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("xfer_idx", 256'(outRkIdx), 256'(e.idx));
        chk("xfer_rk", 256'(outRk), 256'(e.rk));
      end
    end
    if (!outRkValid) chk("rk_zero_when_invalid", 256'(outRk), 256'(0));
  end

  task automatic tick();
    @(posedge inClk);
    #1;
  endtask

  task automatic load_key();
    ld_en = 1'b1;
    tick();
    ld_en = 1'b0;
    tick();
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, 256'(outBusy), 256'(0));
    chk({tag, "_valid"}, 256'(outRkValid), 256'(0));
    chk({tag, "_rk"}, 256'(outRk), 256'(0));
    chk({tag, "_idx"}, 256'(outRkIdx), 256'(0));
    chk({tag, "_wr"}, 256'(outKeyWr), 256'(0));
    chk({tag, "_kdata"}, outKeyData, 256'(0));
    chk({tag, "_krcon"}, 256'(outKeyRcon), 256'(0));
    chk({tag, "_done"}, 256'(outDone), 256'(0));
  endtask

  task automatic run_to_done(input string tag, input int base);
    int n;
    n = 0;
    while (!outDone && n < 300) begin
      tick();
      n++;
    end
    chk({tag, "_done_seen"}, 256'(outDone), 256'(1));
    chk({tag, "_busy_in_done"}, 256'(outBusy), 256'(1));
    tick();
    chk({tag, "_done_pulse_end"}, 256'(outDone), 256'(0));
    chk({tag, "_idle_busy"}, 256'(outBusy), 256'(0));
    chk({tag, "_xfer_count"}, 256'(xfers - base), 256'(15));
    chk({tag, "_sb_empty"}, 256'(sb.size()), 256'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int base;
    int n;
    build_model();
    inRst = 1'b1; inStart = 1'b0; inRkReady = 1'b1; ld_en = 1'b1;
    tick();
    tick();
    ld_en = 1'b0;
    check_idle("reset");
    inRst = 1'b0;
    tick();
    check_idle("post_reset");

    // Full sequence, start pulse during EMIT_LO ignored, write latency.
    push_all();
    base = xfers;
    inStart = 1'b1;
    tick();
    inStart = 1'b0;
    lat = 1;
    chk("r1_busy", 256'(outBusy), 256'(1));
    chk("r1_valid", 256'(outRkValid), 256'(1));
    chk("r1_idx0", 256'(outRkIdx), 256'(0));
    chk("r1_rk0", 256'(outRk), 256'(128'h000102030405060708090a0b0c0d0e0f));
    tick();
    lat = 2;
    chk("r1_idx1", 256'(outRkIdx), 256'(1));
    chk("r1_rk1", 256'(outRk), 256'(128'h101112131415161718191a1b1c1d1e1f));
    inStart = 1'b1;
    tick();
    inStart = 1'b0;
    lat = 3;
    while (!outKeyWr && lat < 10) begin
      tick();
      lat++;
    end
    chk("r1_wr_latency", 256'(lat), 256'(EXP_LAT));
    chk("r1_kdata_hi", 256'(outKeyData[255:128]), 256'(128'ha573c29fa176c498a97fce93a572c09c));
    chk("r1_kdata_full", outKeyData, {wm[8], wm[9], wm[10], wm[11], wm[12], wm[13], wm[14], wm[15]});
    chk("r1_krcon", 256'(outKeyRcon), 256'(8'h02));
    run_to_done("r1", base);
    chk("r1_rk14", 256'(rk14_seen), 256'(128'h24fc79ccbf0979e9371ac23c6d68de36));

    // Back-pressure at idx3.
    load_key();
    push_all();
    base = xfers;
    inStart = 1'b1;
    tick();
    inStart = 1'b0;
    n = 0;
    while (!(outRkValid && outRkIdx == 4'd3) && n < 50) begin
      tick();
      n++;
    end
    inRkReady = 1'b0;
    chk("r2_reached_idx3", 256'(outRkIdx), 256'(3));
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("r2_hold_idx", 256'(outRkIdx), 256'(3));
      chk("r2_hold_rk", 256'(outRk), 256'(exp_rk[3]));
      chk("r2_hold_valid", 256'(outRkValid), 256'(1));
      chk("r2_hold_nowr", 256'(outKeyWr), 256'(0));
    end
    inRkReady = 1'b1;
    run_to_done("r2", base);

    // Reset inside EXPAND after idx7, with a start request alongside.
    load_key();
    push_all();
    base = xfers;
    inStart = 1'b1;
    tick();
    inStart = 1'b0;
    n = 0;
    while (!((xfers - base) == 8 && outBusy && !outRkValid) && n < 100) begin
      tick();
      n++;
    end
    chk("r3_in_expand", 256'(xfers - base), 256'(8));
    inRst = 1'b1;
    inStart = 1'b1;
    tick();
    check_idle("r3_after_reset");
    inRst = 1'b0;
    inStart = 1'b0;
    sb.delete();
    tick();
    check_idle("r3_stays_idle");

    load_key();
    push_all();
    base = xfers;
    inStart = 1'b1;
    tick();
    inStart = 1'b0;
    chk("r3_restart_idx0", 256'(outRkIdx), 256'(0));
    chk("r3_restart_rk0", 256'(outRk), 256'(exp_rk[0]));
    run_to_done("r3", base);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
